audio_pattern_gen: RTL and testbench



---
 rtl/audio_pattern_gen.sv | 136 +++++++++++++
 tb/tb_audio_pattern_gen.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_pattern_gen.sv
// Multi-channel audio test-pattern source.
// Each channel runs its own phase accumulator and produces silence, square,
// sawtooth or triangle samples. A global arithmetic right shift attenuates
// every sample. Frames leave through a valid/full handshake. Phases only
// advance on an accepted transfer, so pitch is independent of the sink rate.
// Optional feature: define AUDIO_PATGEN_FRAME_CNT_EN to add a free-running
// 32-bit frame_count output that counts accepted transfers.
module audio_pattern_gen #(
  parameter int WIDTH      = 24,
  parameter int CHANNELS   = 2,
  parameter int PHASE_BITS = 24
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           enable,
  input  logic [2*CHANNELS-1:0]          mode,
  input  logic [PHASE_BITS*CHANNELS-1:0] phase_inc,
  input  logic [3:0]                     gain_shift,
  input  logic                           audio_full,
  output logic [WIDTH*CHANNELS-1:0]      audio_out,
  output logic                           audio_out_valid
`ifdef AUDIO_PATGEN_FRAME_CNT_EN
  ,
  output logic [31:0]                    frame_count
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    VALID   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [PHASE_BITS-1:0]       phase [CHANNELS];
  logic [WIDTH*CHANNELS-1:0]   frame_nxt;
  logic                        transfer;
  logic                        load;

  // One sample from the top WIDTH bits of a channel's phase.
  function automatic logic signed [WIDTH-1:0] wave_sample(
    input logic [1:0]       m,
    input logic [WIDTH-1:0] p
  );
    logic [WIDTH-1:0]        msb;
    logic [WIDTH-1:0]        q;
    logic [WIDTH-1:0]        u;
    logic signed [WIDTH-1:0] s;
    msb = {1'b1, {(WIDTH-1){1'b0}}};
    // Folding the lower bits gives a ramp that rises in the first half
    // period and falls in the second.
    q   = {p[WIDTH-2:0], 1'b0};
    u   = p[WIDTH-1] ? ~q : q;
    s   = '0;
    case (m)
      2'd0: s = '0;
      // Symmetric square: +(M-1) / -(M-1), never reaching -M.
      2'd1: s = p[WIDTH-1] ? signed'(msb | {{(WIDTH-1){1'b0}}, 1'b1}) : signed'(~msb);
      2'd2: s = signed'(p ^ msb);
      2'd3: s = signed'(u ^ msb);
      default: s = '0;
    endcase
    return s;
  endfunction

  // Attenuation: shift amounts past the sample width saturate to WIDTH-1.
  function automatic logic signed [WIDTH-1:0] apply_gain(
    input logic signed [WIDTH-1:0] s,
    input logic [3:0]              sh
  );
    logic [5:0] amt;
    if ({2'b00, sh} >= 6'(WIDTH)) amt = 6'(WIDTH - 1);
    else                          amt = {2'b00, sh};
    return s >>> amt;
  endfunction

  // Candidate frame from the current phases and controls.
  always_comb begin
    frame_nxt = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      frame_nxt[c*WIDTH +: WIDTH] =
        apply_gain(wave_sample(mode[2*c +: 2], phase[c][PHASE_BITS-1 -: WIDTH]), gain_shift);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; a pending frame is held until the sink takes it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = COMPUTE;
      COMPUTE: state_nxt = VALID;
      VALID:   if (!audio_full) state_nxt = enable ? COMPUTE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / strobe decode from the current state.
  always_comb begin
    audio_out_valid = (state == VALID);
    transfer        = (state == VALID) && !audio_full;
    load            = (state == COMPUTE);
  end

  // Phase accumulators advance once per accepted frame, wrapping silently.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < CHANNELS; c++) phase[c] <= '0;
    end else if (transfer) begin
      for (int c = 0; c < CHANNELS; c++)
        phase[c] <= phase[c] + phase_inc[c*PHASE_BITS +: PHASE_BITS];
    end
  end

  // Output frame register, loaded only in COMPUTE and cleared by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  audio_out <= '0;
    else if (load) audio_out <= frame_nxt;
  end

`ifdef AUDIO_PATGEN_FRAME_CNT_EN
  // Count of accepted frames for firmware sample-rate checks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      frame_count <= '0;
    else if (transfer) frame_count <= frame_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_audio_pattern_gen.sv
// Bench for audio_pattern_gen: directed waveform sequences with literal
// expectations plus randomized traffic checked every cycle by a
// transaction-level model of the generator.
module tb_audio_pattern_gen;

  localparam int W  = 24;
  localparam int CH = 2;
  localparam int PB = 24;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              enable;
  logic [2*CH-1:0]   mode;
  logic [PB*CH-1:0]  phase_inc;
  logic [3:0]        gain_shift;
  logic              audio_full;
  logic [W*CH-1:0]   audio_out;
  logic              audio_out_valid;
`ifdef AUDIO_PATGEN_FRAME_CNT_EN
  logic [31:0]       frame_count;
`endif

  int errors = 0;
  int checks = 0;

  logic [W-1:0] got0 [$];
  logic [W-1:0] got1 [$];

  audio_pattern_gen #(.WIDTH(W), .CHANNELS(CH), .PHASE_BITS(PB)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .mode            (mode),
    .phase_inc       (phase_inc),
    .gain_shift      (gain_shift),
    .audio_full      (audio_full),
    .audio_out       (audio_out),
    .audio_out_valid (audio_out_valid)
`ifdef AUDIO_PATGEN_FRAME_CNT_EN
    ,
    .frame_count     (frame_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference sample from the waveform definitions, in plain integers.
  function automatic logic [W-1:0] model_sample(input int m, input logic [PB-1:0] ph, input int g);
    longint mm;
    longint p;
    longint s;
    int     sh;
    mm = longint'(1) << (W - 1);
    p  = longint'(ph) >> (PB - W);
    case (m)
      1:       s = (p < mm) ? (mm - 1) : -(mm - 1);
      2:       s = p - mm;
      3:       s = (p < mm) ? (2 * p - mm) : (3 * mm - 1 - 2 * p);
      default: s = 0;
    endcase
    sh = (g >= W) ? (W - 1) : g;
    s  = s >>> sh;
    return W'(s);
  endfunction

  // Model: 0 = waiting for enable, 1 = computing, 2 = frame offered.
  int               ms = 0;
  logic [PB-1:0]    mph [CH];
  logic [W*CH-1:0]  last_frame;
  int unsigned      ntx;

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_valid", 64'(audio_out_valid), 64'(0));
      chk("rst_out", 64'(audio_out), 64'(0));
`ifdef AUDIO_PATGEN_FRAME_CNT_EN
      chk("rst_count", 64'(frame_count), 64'(0));
`endif
      ms = 0;
      for (int c = 0; c < CH; c++) mph[c] = '0;
      last_frame = '0;
      ntx = 0;
    end else begin
      chk("valid", 64'(audio_out_valid), 64'(ms == 2));
      chk("frame", 64'(audio_out), 64'(last_frame));
`ifdef AUDIO_PATGEN_FRAME_CNT_EN
      chk("frame_count", 64'(frame_count), 64'(ntx));
`endif
      case (ms)
        0: if (enable) ms = 1;
        1: begin
          for (int c = 0; c < CH; c++)
            last_frame[c*W +: W] = model_sample(int'(mode[2*c +: 2]), mph[c], int'(gain_shift));
          ms = 2;
        end
        default: if (!audio_full) begin
          got0.push_back(audio_out[0 +: W]);
          got1.push_back(audio_out[W +: W]);
          for (int c = 0; c < CH; c++) mph[c] = mph[c] + phase_inc[c*PB +: PB];
          ntx++;
          ms = enable ? 1 : 0;
        end
      endcase
    end
  end

  task automatic do_reset;
    @(posedge clk);
    #1;
    reset_n    = 1'b0;
    enable     = 1'b0;
    audio_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    got0.delete();
    got1.delete();
    reset_n = 1'b1;
  endtask

  task automatic wait_got(input int n, input string nm);
    for (int i = 0; i < 200 && got0.size() < n; i++) begin
      @(posedge clk);
      #1;
    end
    chk(nm, 64'(got0.size() >= n), 64'(1));
  endtask

  task automatic chk_got(input string nm, input int idx, input logic [W-1:0] req);
    if (idx < got0.size()) chk(nm, 64'(got0[idx]), 64'(req));
    else                   chk(nm, 64'hDEAD_BEEF, 64'(req));
  endtask

  task automatic wait_valid(input string nm);
    for (int i = 0; i < 50 && !audio_out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    chk(nm, 64'(audio_out_valid), 64'(1));
  endtask

  initial begin
    reset_n    = 1'b0;
    enable     = 1'b0;
    mode       = '0;
    phase_inc  = '0;
    gain_shift = '0;
    audio_full = 1'b0;
    for (int c = 0; c < CH; c++) mph[c] = '0;
    last_frame = '0;
    ntx        = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 64'(audio_out_valid), 64'(0));
    chk("reset_out", 64'(audio_out), 64'(0));
    reset_n = 1'b1;

    // Sawtooth with latency check.
    mode      = 4'b0010;
    phase_inc = {24'h000000, 24'h100000};
    @(posedge clk);
    #1 enable = 1'b1;
    @(posedge clk);
    #1 chk("lat_n1", 64'(audio_out_valid), 64'(0));
    @(posedge clk);
    #1 chk("lat_n2", 64'(audio_out_valid), 64'(1));
    wait_got(3, "saw_wait");
    chk_got("saw0", 0, 24'h800000);
    chk_got("saw1", 1, 24'h900000);
    chk_got("saw2", 2, 24'hA00000);

    // Backpressure: hold 10 cycles, drop enable midway.
    wait_valid("bp_wait");
    audio_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_valid", 64'(audio_out_valid), 64'(1));
      chk("bp_hold_out", 64'(audio_out[0 +: W]), 64'(24'hB00000));
      if (i == 4) enable = 1'b0;
    end
    audio_full = 1'b0;
    @(posedge clk);
    #1;
    chk_got("bp_sample", 3, 24'hB00000);
    chk("bp_count", 64'(got0.size()), 64'(4));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 chk("bp_idle", 64'(audio_out_valid), 64'(0));
    end
`ifdef AUDIO_PATGEN_FRAME_CNT_EN
    chk("bp_frame_count", 64'(frame_count), 64'(4));
`endif

    // Square, ch1 silent.
    do_reset();
    mode       = 4'b0001;
    phase_inc  = {24'h123456, 24'h400000};
    gain_shift = 4'd0;
    enable     = 1'b1;
    wait_got(4, "sq_wait");
    chk_got("sq0", 0, 24'h7FFFFF);
    chk_got("sq1", 1, 24'h7FFFFF);
    chk_got("sq2", 2, 24'h800001);
    chk_got("sq3", 3, 24'h800001);
    for (int i = 0; i < got1.size(); i++) chk("ch1_silent", 64'(got1[i]), 64'(0));

    // Square with one bit of attenuation (arithmetic shift floors negatives).
    do_reset();
    gain_shift = 4'd1;
    enable     = 1'b1;
    wait_got(4, "sqg_wait");
    chk_got("sqg0", 0, 24'h3FFFFF);
    chk_got("sqg1", 1, 24'h3FFFFF);
    chk_got("sqg2", 2, 24'hC00000);
    chk_got("sqg3", 3, 24'hC00000);

    // Triangle through one full wrap.
    do_reset();
    mode       = 4'b0011;
    gain_shift = 4'd0;
    enable     = 1'b1;
    wait_got(5, "tri_wait");
`ifdef AUDIO_PATGEN_FRAME_CNT_EN
    chk("tri_frame_count", 64'(frame_count), 64'(5));
`endif
    chk_got("tri0", 0, 24'h800000);
    chk_got("tri1", 1, 24'h000000);
    chk_got("tri2", 2, 24'h7FFFFF);
    chk_got("tri3", 3, 24'hFFFFFF);
    chk_got("tri4", 4, 24'h800000);

    // Randomized traffic; the per-cycle model does the checking.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 15) == 0) begin
        mode       = 4'($urandom);
        phase_inc  = 48'({$urandom, $urandom});
        gain_shift = 4'($urandom_range(0, 15));
      end
      enable     = ($urandom_range(0, 7) != 0);
      audio_full = ($urandom_range(0, 2) == 0);
    end

    // Asynchronous reset while a frame is pending.
    enable     = 1'b1;
    audio_full = 1'b1;
    mode       = 4'b0101;
    wait_valid("ar_wait");
    #2 reset_n = 1'b0;
    #1;
    chk("ar_valid", 64'(audio_out_valid), 64'(0));
    chk("ar_out", 64'(audio_out), 64'(0));
`ifdef AUDIO_PATGEN_FRAME_CNT_EN
    chk("ar_count", 64'(frame_count), 64'(0));
`endif
    @(posedge clk);
    #1;
    audio_full = 1'b0;
    enable     = 1'b0;
    reset_n    = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
